// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, RAM port state,
// and the memory responder's sequencing states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE,
        BUSY,
        ACCESS,
        ERROR
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE,
        DREQ,
        IREQ,
        DONE
    } resp_state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-facing bundle between the datapath requesters and
// the memory responder; mr is the responder's view.
interface mem_responder_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  dmemREN;
    logic  dmemWEN;
    word_t dmemaddr;
    word_t dmemstore;
    logic  ihit;
    word_t imemload;
    logic  dhit;
    word_t dmemload;
    logic  err;

    modport mr (
        input  imemREN, imemaddr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output ihit, imemload,
        output dhit, dmemload, err
    );

    modport ru (
        output imemREN, imemaddr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  ihit, imemload,
        input  dhit, dmemload, err
    );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates fetch and data requests onto
// one RAM port (data first) and returns ihit/dhit pulses.
module mem_responder
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic      CLK,
    input  logic      RST,
    input  logic      imemREN,
    input  word_t     imemaddr,
    input  logic      dmemREN,
    input  logic      dmemWEN,
    input  word_t     dmemaddr,
    input  word_t     dmemstore,
    output logic      ihit,
    output word_t     imemload,
    output logic      dhit,
    output word_t     dmemload,
    output logic      err,
    output logic      ramREN,
    output logic      ramWEN,
    output word_t     ramaddr,
    output word_t     ramstore,
    input  word_t     ramload,
    input  ramstate_t ramstate
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    resp_state_t   state;
    logic [CW-1:0] cnt;
    logic          wen_q;
    logic          timed_out;

    assign timed_out = (cnt == CNT_LAST);

    // Request sequencer; every output is a register so the RAM
    // strobes and hit pulses are glitch-free and drop with RST.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            cnt      <= '0;
            wen_q    <= 1'b0;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            err      <= 1'b0;
            imemload <= '0;
            dmemload <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dmemREN || dmemWEN) begin
                        state    <= DREQ;
                        cnt      <= '0;
                        wen_q    <= dmemWEN;
                        ramaddr  <= dmemaddr;
                        ramstore <= dmemstore;
                        ramWEN   <= dmemWEN;
                        ramREN   <= ~dmemWEN;
                    end else if (imemREN) begin
                        state   <= IREQ;
                        cnt     <= '0;
                        wen_q   <= 1'b0;
                        ramaddr <= imemaddr;
                        ramREN  <= 1'b1;
                        ramWEN  <= 1'b0;
                    end
                end
                DREQ, IREQ: begin
                    if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (ramstate == ACCESS) begin
                        state  <= DONE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        if (state == IREQ) begin
                            ihit     <= 1'b1;
                            imemload <= ramload;
                        end else begin
                            dhit <= 1'b1;
                            if (!wen_q) begin
                                dmemload <= ramload;
                            end
                        end
                    end else if (ramstate == ERROR || timed_out) begin
                        state  <= DONE;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        err    <= 1'b1;
                        ihit   <= (state == IREQ);
                        dhit   <= (state == DREQ);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    ihit  <= 1'b0;
                    dhit  <= 1'b0;
                    err   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
